// File: rtl/id_ex_stage.sv
// Decode/issue stage: decodes IF/ID, reads the register file and fills the ID/EX pipeline register.
// Latency: 1 cycle ID->EX (register file addresses are combinational from if_instr).
// Backpressure: id_stall holds IF/ID and PC on a load-use hazard or ex_hold; flush overrides both.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   if_valid/if_instr/if_pc          instruction presented by IF/ID
//   rf_rs1_addr/rf_rs2_addr          register file read addresses (combinational)
//   rf_rs1_data/rf_rs2_data          register file read data (already WB-bypassed)
//   ex_hold, flush                   EX backpressure, taken branch/jump kill
//   id_stall                         combinational hold request to IF/ID and PC
//   ex_*                             ID/EX pipeline register contents
// Optional feature (macro HAZARD_PERF_CNT_EN): saturating perf_stall_cnt / perf_flush_cnt outputs.

module id_ex_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            ex_hold,
    input  logic            flush,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [31:0]     ex_instr,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    output logic            ex_is_load
);

    // Opcodes
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // ------------------------------------------------------------------
    // Combinational decode of the IF/ID instruction
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic            dec_is_load;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            load_use;

    assign opcode      = if_instr[6:0];
    assign dec_rs1     = if_instr[19:15];
    assign dec_rs2     = if_instr[24:20];
    assign dec_rd      = if_instr[11:7];
    assign dec_is_load = (opcode == OP_LOAD);

    assign rf_rs1_addr = dec_rs1;
    assign rf_rs2_addr = dec_rs2;

    always_comb begin
        dec_imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR:
                dec_imm = {{20{if_instr[31]}}, if_instr[31:20]};
            OP_STORE:
                dec_imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            OP_BRANCH:
                dec_imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                           if_instr[30:25], if_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                dec_imm = {if_instr[31:12], 12'h000};
            OP_JAL:
                dec_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
            default:
                dec_imm = '0;
        endcase
    end

    assign uses_rs1 = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [31:0]     instr_q,    instr_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [4:0]      rd_q,       rd_d;
    logic            is_load_q,  is_load_d;

    // A load in EX writing a non-zero register that this instruction reads.
    // Once the bubble is inserted EX no longer holds the load, so the hazard
    // clears by itself after exactly one cycle.
    assign load_use = valid_q && is_load_q && (rd_q != 5'd0) && if_valid &&
                      ((uses_rs1 && (dec_rs1 == rd_q)) ||
                       (uses_rs2 && (dec_rs2 == rd_q)));

    assign id_stall = (load_use || ex_hold) && !flush;

    always_comb begin
        // Default: hold every field
        valid_d    = valid_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        is_load_d  = is_load_q;

        if (flush || (!ex_hold && (load_use || !if_valid))) begin
            // Bubble: kill the slot. Register indices are cleared so a bubble
            // can never match in the EX/MEM forwarding compare.
            valid_d   = 1'b0;
            instr_d   = NOP_INSTR;
            rs1_d     = 5'd0;
            rs2_d     = 5'd0;
            rd_d      = 5'd0;
            is_load_d = 1'b0;
        end else if (!ex_hold) begin
            valid_d    = 1'b1;
            pc_d       = if_pc;
            instr_d    = if_instr;
            rs1_data_d = rf_rs1_data;
            rs2_data_d = rf_rs2_data;
            imm_d      = dec_imm;
            rs1_d      = dec_rs1;
            rs2_d      = dec_rs2;
            rd_d       = dec_rd;
            is_load_d  = dec_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            is_load_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            is_load_q  <= is_load_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_instr    = instr_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_is_load  = is_load_q;

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating hazard counters
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && !flush && !ex_hold && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
